// File: rtl/ti_pipe_in_unpacker.sv
// Pipe-in receive buffer: 16-bit words land in a block-RAM FIFO and leave
// as a low-byte-first 8-bit valid/ready stream, with free space reported back to the host.
module ti_pipe_in_unpacker #(
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic        ti_clk,
    input  logic        ti_rst,
    input  logic        ti_in_data_en,
    input  logic [15:0] ti_in_data,
    output logic [15:0] ti_in_available,
    output logic        ti_in_overflow,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready
);
    localparam int AW    = MEM_ADDR_WIDTH;
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] DEPTH_CNT = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {ST_IDLE, ST_LO, ST_HI} state_t;

    logic [15:0]   mem [DEPTH];
    logic [15:0]   rd_data_q;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [15:0]   avail_q, avail_d;
    logic          overflow_q, overflow_d;
    state_t        state_q, state_d;
    logic [15:0]   word_q, word_d;
    logic          pf_valid_q, pf_valid_d;

    logic full, empty, push, pop, pf_take, handshake;

    assign full      = (count_q == DEPTH_CNT);
    assign empty     = (count_q == '0);
    assign push      = ti_in_data_en & ~full;
    assign out_valid = (state_q != ST_IDLE);
    assign handshake = out_valid & out_ready;

    // The RAM output register doubles as the prefetch slot: a word read
    // from the FIFO stays there until the unpacker takes it, and no new
    // read is issued in LO/HI while it is occupied.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        pop     = 1'b0;
        pf_take = 1'b0;
        case (state_q)
            ST_IDLE: begin
                pop = ~empty;
                if (pf_valid_q) begin
                    word_d  = rd_data_q;
                    pf_take = 1'b1;
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                pop = ~empty & ~pf_valid_q;
                if (handshake) begin
                    state_d = ST_HI;
                end
            end
            ST_HI: begin
                pop = ~empty & ~pf_valid_q;
                if (handshake) begin
                    if (pf_valid_q) begin
                        word_d  = rd_data_q;
                        pf_take = 1'b1;
                        state_d = ST_LO;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pf_valid_d = pop | (pf_valid_q & ~pf_take);
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        avail_d    = 16'(DEPTH) - 16'(count_d);
        overflow_d = overflow_q | (ti_in_data_en & full);
    end

    always_comb begin
        case (state_q)
            ST_LO:   out_data = word_q[7:0];
            ST_HI:   out_data = word_q[15:8];
            default: out_data = 8'h00;
        endcase
    end

    always_ff @(posedge ti_clk) begin
        if (ti_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            avail_q    <= 16'(DEPTH);
            overflow_q <= 1'b0;
            state_q    <= ST_IDLE;
            word_q     <= '0;
            pf_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            avail_q    <= avail_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            word_q     <= word_d;
            pf_valid_q <= pf_valid_d;
        end
    end

    // Plain write port plus read-enabled registered read so it maps onto block RAM.
    always_ff @(posedge ti_clk) begin
        if (push && !ti_rst) begin
            mem[wr_ptr_q] <= ti_in_data;
        end
        if (pop) begin
            rd_data_q <= mem[rd_ptr_q];
        end
    end

    assign ti_in_available = avail_q;
    assign ti_in_overflow  = overflow_q;

endmodule

// File: tb/tb_ti_pipe_in_unpacker.sv
// Self-checking bench for ti_pipe_in_unpacker: directed steps in one initial
// block, byte scoreboard filled on write and drained by a negedge monitor.
module tb_ti_pipe_in_unpacker;
    logic        ti_clk = 1'b0;
    logic        ti_rst = 1'b1;
    logic        ti_in_data_en = 1'b0;
    logic [15:0] ti_in_data = '0;
    logic [15:0] ti_in_available;
    logic        ti_in_overflow;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready = 1'b0;

    int checks = 0;
    int failures = 0;
    int rx_count = 0;
    logic [7:0] exp_q [$];
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = '0;

    ti_pipe_in_unpacker #(.MEM_ADDR_WIDTH(10)) dut (
        .ti_clk          (ti_clk),
        .ti_rst          (ti_rst),
        .ti_in_data_en   (ti_in_data_en),
        .ti_in_data      (ti_in_data),
        .ti_in_available (ti_in_available),
        .ti_in_overflow  (ti_in_overflow),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .out_ready       (out_ready)
    );

    always #5 ti_clk = ~ti_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ti_clk);
        #1;
    endtask

    task automatic push_word(input logic [15:0] w);
        exp_q.push_back(w[7:0]);
        exp_q.push_back(w[15:8]);
    endtask

    task automatic wait_drain(input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        check(tag, exp_q.size(), 0);
    endtask

    // Byte monitor: scoreboard compare on handshake, stability during stalls.
    always @(negedge ti_clk) begin
        if (ti_rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                rx_count++;
                checks++;
                assert (exp_q.size() != 0) else begin
                    failures++;
                    $error("FAIL extra_byte observed=%0h expected=none", out_data);
                end
                if (exp_q.size() != 0) check("byte", out_data, exp_q.pop_front());
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    initial begin
        int rx_before;
        logic [15:0] w;

        // Reset defaults
        ti_rst = 1'b1;
        tick();
        tick();
        ti_rst = 1'b0;
        check("rst_avail", ti_in_available, 1024);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 8'h00);
        check("rst_overflow", ti_in_overflow, 0);
        tick();
        check("rst_valid_after", out_valid, 0);

        // Single word: A55A with out_ready high
        out_ready = 1'b1;
        ti_in_data_en = 1'b1;
        ti_in_data = 16'hA55A;
        push_word(16'hA55A);
        tick();
        ti_in_data_en = 1'b0;
        check("single_avail_k", ti_in_available, 1023);
        check("single_valid_k", out_valid, 0);
        tick();
        check("single_avail_pop", ti_in_available, 1024);
        check("single_valid_k1", out_valid, 0);
        tick();
        check("single_valid_k2", out_valid, 1);
        check("single_lo", out_data, 8'h5A);
        tick();
        check("single_valid_k3", out_valid, 1);
        check("single_hi", out_data, 8'hA5);
        tick();
        check("single_valid_k4", out_valid, 0);
        check("single_drained", exp_q.size(), 0);

        // Burst of 8 words, no stall: valid must be continuous for 16 bytes
        for (int c = 0; c < 22; c++) begin
            ti_in_data_en = (c < 8);
            ti_in_data = 16'h0100 + 16'(c);
            if (c < 8) push_word(16'h0100 + 16'(c));
            tick();
            check("burst_valid", out_valid, (c >= 2 && c <= 17) ? 1 : 0);
        end
        ti_in_data_en = 1'b0;
        check("burst_drained", exp_q.size(), 0);

        // Backpressure and overflow: 1027 writes, 1026 fit
        out_ready = 1'b0;
        for (int i = 0; i < 1027; i++) begin
            w = 16'(i * 37 + 5);
            ti_in_data_en = 1'b1;
            ti_in_data = w;
            if (i < 1026) push_word(w);
            tick();
            if (i == 1025) begin
                check("ovf_avail_zero", ti_in_available, 0);
                check("ovf_not_yet", ti_in_overflow, 0);
            end
        end
        ti_in_data_en = 1'b0;
        check("ovf_set", ti_in_overflow, 1);
        check("ovf_avail_full", ti_in_available, 0);
        rx_before = rx_count;
        out_ready = 1'b1;
        wait_drain(2200, "ovf_drain");
        tick();
        tick();
        check("ovf_bytes", rx_count - rx_before, 2052);
        check("ovf_idle", out_valid, 0);
        check("ovf_sticky", ti_in_overflow, 1);
        check("ovf_avail_back", ti_in_available, 1024);

        // Mid-stream reset while HI is stalled
        out_ready = 1'b0;
        ti_in_data_en = 1'b1;
        ti_in_data = 16'hBEEF;
        push_word(16'hBEEF);
        tick();
        ti_in_data_en = 1'b0;
        tick();
        tick();
        check("mid_lo_valid", out_valid, 1);
        check("mid_lo", out_data, 8'hEF);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("mid_hi", out_data, 8'hBE);
        tick();
        ti_rst = 1'b1;
        tick();
        ti_rst = 1'b0;
        exp_q.delete();
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_avail", ti_in_available, 1024);
        check("mid_rst_overflow", ti_in_overflow, 0);
        rx_before = rx_count;
        out_ready = 1'b1;
        ti_in_data_en = 1'b1;
        ti_in_data = 16'h1234;
        push_word(16'h1234);
        tick();
        ti_in_data_en = 1'b0;
        wait_drain(20, "mid_drain");
        tick();
        tick();
        check("mid_bytes", rx_count - rx_before, 2);
        check("mid_idle", out_valid, 0);

        // Random handshake with 30% ready and random write gaps
        for (int n = 0; n < 5000; n++) begin
            int gap;
            gap = int'($urandom_range(0, 14));
            for (int g = 0; g < gap; g++) begin
                out_ready = ($urandom_range(0, 99) < 30);
                tick();
            end
            w = 16'($urandom);
            ti_in_data_en = 1'b1;
            ti_in_data = w;
            push_word(w);
            out_ready = ($urandom_range(0, 99) < 30);
            tick();
            ti_in_data_en = 1'b0;
        end
        out_ready = 1'b1;
        wait_drain(5000, "rand_drain");
        tick();
        tick();
        check("rand_idle", out_valid, 0);
        check("rand_no_overflow", ti_in_overflow, 0);
        check("rand_avail", ti_in_available, 1024);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
